// File: rtl/store_commit_buffer_pkg.sv
// Shared core constants and types for the store commit buffer and its neighbours.
package store_commit_buffer_pkg;

  // Existing core depth constants (ROB and memory reservation station).
  localparam int ROB_DEPTH      = 16;
  localparam int ROB_DEPTH_BITS = 4;
  localparam int MRS_DEPTH      = 8;
  localparam int MRS_DEPTH_BITS = 3;

  // Store commit buffer geometry.
  localparam int SB_DEPTH      = 8;
  localparam int SB_DEPTH_BITS = 3;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  typedef logic [SB_DEPTH_BITS:0] sb_ptr_t;

  typedef struct packed {
    logic                      valid;
    logic                      committed;
    logic [ROB_DEPTH_BITS-1:0] tag;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH-1:0]     data;
  } sb_entry_t;

  typedef enum logic [0:0] {
    SB_IDLE  = 1'b0,
    SB_ISSUE = 1'b1
  } sb_drain_state_t;

  localparam sb_entry_t SB_ENTRY_NULL = '{
    valid:     1'b0,
    committed: 1'b0,
    tag:       {ROB_DEPTH_BITS{1'b0}},
    addr:      {ADDR_WIDTH{1'b0}},
    data:      {DATA_WIDTH{1'b0}}
  };

  // Buffer is full when the slot indices match but the wrap bits differ.
  function automatic logic sb_ptr_full(input sb_ptr_t head, input sb_ptr_t tail);
    return (head[SB_DEPTH_BITS] != tail[SB_DEPTH_BITS]) &&
           (head[SB_DEPTH_BITS-1:0] == tail[SB_DEPTH_BITS-1:0]);
  endfunction

  // Slot index of a pointer (wrap bit dropped).
  function automatic logic [SB_DEPTH_BITS-1:0] sb_ptr_idx(input sb_ptr_t ptr);
    return ptr[SB_DEPTH_BITS-1:0];
  endfunction

endpackage

// File: rtl/store_commit_buffer_if.sv
// Bundle of store-in, commit, load-lookup, D-cache write and status signals.
interface store_commit_buffer_if;
  import store_commit_buffer_pkg::*;

  logic                      st_valid;
  logic [ROB_DEPTH_BITS-1:0] st_tag;
  logic [ADDR_WIDTH-1:0]     st_addr;
  logic [DATA_WIDTH-1:0]     st_data;
  logic                      st_ready;
  logic                      commit_valid;
  logic [ROB_DEPTH_BITS-1:0] commit_tag;
  logic                      flush;
  logic [ADDR_WIDTH-1:0]     ld_addr;
  logic                      ld_match;
  logic [DATA_WIDTH-1:0]     ld_fwd_data;
  logic                      dc_wr_valid;
  logic [ADDR_WIDTH-1:0]     dc_wr_addr;
  logic [DATA_WIDTH-1:0]     dc_wr_data;
  logic                      dc_stall;
  logic [SB_DEPTH_BITS:0]    sb_count;
  logic                      sb_empty;
  logic                      commit_err;

  modport master (
    output st_valid, st_tag, st_addr, st_data, commit_valid, commit_tag,
           flush, ld_addr, dc_stall,
    input  st_ready, ld_match, ld_fwd_data, dc_wr_valid, dc_wr_addr,
           dc_wr_data, sb_count, sb_empty, commit_err
  );

  modport slave (
    input  st_valid, st_tag, st_addr, st_data, commit_valid, commit_tag,
           flush, ld_addr, dc_stall,
    output st_ready, ld_match, ld_fwd_data, dc_wr_valid, dc_wr_addr,
           dc_wr_data, sb_count, sb_empty, commit_err
  );

endinterface

// File: rtl/store_commit_buffer_sb_addr_match.sv
// Youngest-hit address search over the buffer slots plus the drain output register.
module sb_addr_match
  import store_commit_buffer_pkg::*;
#(
  parameter int N  = SB_DEPTH,
  parameter int IW = SB_DEPTH_BITS
) (
  input  logic [N-1:0]          ent_valid,
  input  logic [ADDR_WIDTH-1:0] ent_addr [N],
  input  logic [DATA_WIDTH-1:0] ent_data [N],
  input  logic [IW-1:0]         tail_idx,
  input  logic                  out_valid,
  input  logic [ADDR_WIDTH-1:0] out_addr,
  input  logic [DATA_WIDTH-1:0] out_data,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] hit_data
);

  logic sel_s;

  // Sweep from oldest (output register, then tail-N) to youngest (tail-1) so the youngest hit wins.
  always_comb begin
    sel_s    = out_valid & (out_addr == ld_addr);
    hit      = sel_s;
    hit_data = sel_s ? out_data : {DATA_WIDTH{1'b0}};
    for (int k = N; k >= 1; k--) begin
      sel_s    = ent_valid[tail_idx - IW'(k)] & (ent_addr[tail_idx - IW'(k)] == ld_addr);
      hit      = hit | sel_s;
      hit_data = sel_s ? ent_data[tail_idx - IW'(k)] : hit_data;
    end
  end

endmodule

// File: rtl/store_commit_buffer.sv
// Speculative store buffer: in-order commit, one-at-a-time D-cache drain, load forwarding.
module store_commit_buffer
  import store_commit_buffer_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  store_commit_buffer_if.slave bus
);

  localparam sb_ptr_t PTR_ONE = sb_ptr_t'(1'b1);

  sb_entry_t                entries_r [SB_DEPTH];
  sb_ptr_t                  head_r;
  sb_ptr_t                  cm_r;
  sb_ptr_t                  tail_r;
  sb_drain_state_t          state_r;
  logic                     dc_wr_valid_r;
  logic [ADDR_WIDTH-1:0]    out_addr_r;
  logic [DATA_WIDTH-1:0]    out_data_r;
  logic                     commit_err_r;

  logic [SB_DEPTH_BITS-1:0] head_idx_s;
  logic [SB_DEPTH_BITS-1:0] cm_idx_s;
  logic [SB_DEPTH_BITS-1:0] tail_idx_s;
  logic                     full_s;
  logic                     enq_s;
  logic                     commit_ok_s;
  logic                     head_ready_s;
  logic                     load_s;
  sb_ptr_t                  cm_next_s;
  logic [SB_DEPTH-1:0]      ent_valid_s;
  logic [ADDR_WIDTH-1:0]    ent_addr_s [SB_DEPTH];
  logic [DATA_WIDTH-1:0]    ent_data_s [SB_DEPTH];
  logic                     ld_hit_s;
  logic [DATA_WIDTH-1:0]    ld_data_s;

  // Decode enqueue, commit legality and drain load from the registered state.
  always_comb begin
    head_idx_s   = sb_ptr_idx(head_r);
    cm_idx_s     = sb_ptr_idx(cm_r);
    tail_idx_s   = sb_ptr_idx(tail_r);
    full_s       = sb_ptr_full(head_r, tail_r);
    enq_s        = bus.st_valid & ~full_s & ~bus.flush;
    commit_ok_s  = bus.commit_valid & entries_r[cm_idx_s].valid &
                   ~entries_r[cm_idx_s].committed &
                   (entries_r[cm_idx_s].tag == bus.commit_tag);
    cm_next_s    = commit_ok_s ? (cm_r + PTR_ONE) : cm_r;
    head_ready_s = entries_r[head_idx_s].valid & entries_r[head_idx_s].committed;
    case (state_r)
      SB_IDLE:  load_s = head_ready_s;
      SB_ISSUE: load_s = head_ready_s & ~bus.dc_stall;
      default:  load_s = 1'b0;
    endcase
  end

  // Per-slot updates: drain frees head, commit marks cm, enqueue fills tail, flush drops speculation.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (!rst_n) begin
        entries_r[i] <= SB_ENTRY_NULL;
      end else if (load_s && (SB_DEPTH_BITS'(i) == head_idx_s)) begin
        entries_r[i].valid     <= 1'b0;
        entries_r[i].committed <= 1'b0;
      end else if (commit_ok_s && (SB_DEPTH_BITS'(i) == cm_idx_s)) begin
        entries_r[i].committed <= 1'b1;
      end else if (enq_s && (SB_DEPTH_BITS'(i) == tail_idx_s)) begin
        entries_r[i] <= '{valid: 1'b1, committed: 1'b0, tag: bus.st_tag,
                          addr: bus.st_addr, data: bus.st_data};
      end else if (bus.flush && !entries_r[i].committed) begin
        entries_r[i].valid <= 1'b0;
      end
    end
  end

  // Pointer advance; a flush pulls tail back to the post-commit cm pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_r <= {(SB_DEPTH_BITS+1){1'b0}};
      cm_r   <= {(SB_DEPTH_BITS+1){1'b0}};
      tail_r <= {(SB_DEPTH_BITS+1){1'b0}};
    end else begin
      head_r <= load_s ? (head_r + PTR_ONE) : head_r;
      cm_r   <= cm_next_s;
      if (bus.flush) begin
        tail_r <= cm_next_s;
      end else begin
        tail_r <= enq_s ? (tail_r + PTR_ONE) : tail_r;
      end
    end
  end

  // Drain FSM with registered D-cache request; back-to-back issue when the next head is committed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= SB_IDLE;
      dc_wr_valid_r <= 1'b0;
      out_addr_r    <= {ADDR_WIDTH{1'b0}};
      out_data_r    <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        SB_IDLE: begin
          if (load_s) begin
            state_r       <= SB_ISSUE;
            dc_wr_valid_r <= 1'b1;
            out_addr_r    <= entries_r[head_idx_s].addr;
            out_data_r    <= entries_r[head_idx_s].data;
          end else begin
            state_r       <= SB_IDLE;
            dc_wr_valid_r <= 1'b0;
          end
        end
        SB_ISSUE: begin
          if (bus.dc_stall) begin
            state_r       <= SB_ISSUE;
            dc_wr_valid_r <= 1'b1;
          end else if (load_s) begin
            state_r       <= SB_ISSUE;
            dc_wr_valid_r <= 1'b1;
            out_addr_r    <= entries_r[head_idx_s].addr;
            out_data_r    <= entries_r[head_idx_s].data;
          end else begin
            state_r       <= SB_IDLE;
            dc_wr_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r       <= SB_IDLE;
          dc_wr_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flag for any commit that does not match the oldest uncommitted store.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      commit_err_r <= 1'b0;
    end else if (bus.commit_valid && !commit_ok_s) begin
      commit_err_r <= 1'b1;
    end
  end

  // Flatten slot fields for the lookup search.
  always_comb begin
    for (int i = 0; i < SB_DEPTH; i++) begin
      ent_valid_s[i] = entries_r[i].valid;
      ent_addr_s[i]  = entries_r[i].addr;
      ent_data_s[i]  = entries_r[i].data;
    end
  end

  sb_addr_match #(
    .N  (SB_DEPTH),
    .IW (SB_DEPTH_BITS)
  ) u_match (
    .ent_valid (ent_valid_s),
    .ent_addr  (ent_addr_s),
    .ent_data  (ent_data_s),
    .tail_idx  (tail_idx_s),
    .out_valid (state_r == SB_ISSUE),
    .out_addr  (out_addr_r),
    .out_data  (out_data_r),
    .ld_addr   (bus.ld_addr),
    .hit       (ld_hit_s),
    .hit_data  (ld_data_s)
  );

  assign bus.st_ready    = ~full_s;
  assign bus.sb_count    = tail_r - head_r;
  assign bus.sb_empty    = (tail_r == head_r) && (state_r == SB_IDLE);
  assign bus.dc_wr_valid = dc_wr_valid_r;
  assign bus.dc_wr_addr  = out_addr_r;
  assign bus.dc_wr_data  = out_data_r;
  assign bus.commit_err  = commit_err_r;
  assign bus.ld_match    = ld_hit_s;
  assign bus.ld_fwd_data = ld_data_s;

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed self-checking bench for the store commit buffer.
module tb_store_commit_buffer;

  logic clk;
  logic rst_n;
  int   check_cnt;
  int   fail_cnt;
  int   cyc;

  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          wr_cyc_q  [$];

  store_commit_buffer_if bus ();

  store_commit_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted D-cache write, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n && bus.dc_wr_valid && !bus.dc_stall) begin
      wr_addr_q.push_back(bus.dc_wr_addr);
      wr_data_q.push_back(bus.dc_wr_data);
      wr_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [3:0] tag, input logic [31:0] addr, input logic [31:0] data);
    bus.st_valid = 1'b1;
    bus.st_tag   = tag;
    bus.st_addr  = addr;
    bus.st_data  = data;
    step();
    bus.st_valid = 1'b0;
  endtask

  task automatic commit(input logic [3:0] tag);
    bus.commit_valid = 1'b1;
    bus.commit_tag   = tag;
    step();
    bus.commit_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 40 && !bus.sb_empty; n++) step();
    check_value(tag, 64'(bus.sb_empty), 64'd1);
  endtask

  initial begin
    check_cnt        = 0;
    fail_cnt         = 0;
    cyc              = 0;
    rst_n            = 1'b0;
    bus.st_valid     = 1'b0;
    bus.st_tag       = 4'd0;
    bus.st_addr      = 32'd0;
    bus.st_data      = 32'd0;
    bus.commit_valid = 1'b0;
    bus.commit_tag   = 4'd0;
    bus.flush        = 1'b0;
    bus.ld_addr      = 32'd0;
    bus.dc_stall     = 1'b0;

    // Reset state
    do_reset();
    check_value("rst_st_ready",   64'(bus.st_ready),    64'd1);
    check_value("rst_sb_empty",   64'(bus.sb_empty),    64'd1);
    check_value("rst_sb_count",   64'(bus.sb_count),    64'd0);
    check_value("rst_wr_valid",   64'(bus.dc_wr_valid), 64'd0);
    check_value("rst_wr_addr",    64'(bus.dc_wr_addr),  64'd0);
    check_value("rst_wr_data",    64'(bus.dc_wr_data),  64'd0);
    check_value("rst_ld_match",   64'(bus.ld_match),    64'd0);
    check_value("rst_commit_err", 64'(bus.commit_err),  64'd0);

    // Single store: commit in cycle c, write visible in c+2, empty in c+3
    clear_writes();
    enq(4'd3, 32'h100, 32'hAA);
    check_value("lat_count",   64'(bus.sb_count), 64'd1);
    check_value("lat_nempty",  64'(bus.sb_empty), 64'd0);
    commit(4'd3);
    check_value("lat_c1_valid", 64'(bus.dc_wr_valid), 64'd0);
    step();
    check_value("lat_c2_valid", 64'(bus.dc_wr_valid), 64'd1);
    check_value("lat_c2_addr",  64'(bus.dc_wr_addr),  64'h100);
    check_value("lat_c2_data",  64'(bus.dc_wr_data),  64'hAA);
    step();
    check_value("lat_c3_valid", 64'(bus.dc_wr_valid), 64'd0);
    check_value("lat_c3_empty", 64'(bus.sb_empty),    64'd1);
    check_value("lat_nwrites",  64'(wr_addr_q.size()), 64'd1);

    // Forwarding: youngest matching store wins; then flush everything uncommitted
    enq(4'd1, 32'h200, 32'h11);
    enq(4'd2, 32'h200, 32'h22);
    bus.ld_addr = 32'h200;
    #1;
    check_value("fwd_match",   64'(bus.ld_match),    64'd1);
    check_value("fwd_data",    64'(bus.ld_fwd_data), 64'h22);
    bus.ld_addr = 32'h204;
    #1;
    check_value("fwd_nomatch", 64'(bus.ld_match),    64'd0);
    check_value("fwd_nodata",  64'(bus.ld_fwd_data), 64'd0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check_value("fwd_flush_count", 64'(bus.sb_count), 64'd0);
    check_value("fwd_flush_empty", 64'(bus.sb_empty), 64'd1);
    bus.ld_addr = 32'h200;
    #1;
    check_value("fwd_flush_match", 64'(bus.ld_match), 64'd0);

    // Fill all eight slots, reject a ninth, then drain back-to-back across the wrap
    for (int i = 0; i < 8; i++) enq(4'(i), 32'h1000 + 32'(4 * i), 32'hD0 + 32'(i));
    check_value("fill_ready", 64'(bus.st_ready), 64'd0);
    check_value("fill_count", 64'(bus.sb_count), 64'd8);
    enq(4'd8, 32'h1FFC, 32'hEE);
    check_value("fill_ninth_count", 64'(bus.sb_count), 64'd8);
    bus.ld_addr = 32'h1FFC;
    #1;
    check_value("fill_ninth_match", 64'(bus.ld_match), 64'd0);
    clear_writes();
    for (int i = 0; i < 8; i++) commit(4'(i));
    wait_idle("fill_idle");
    check_value("fill_nwrites", 64'(wr_addr_q.size()), 64'd8);
    if (wr_addr_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check_value($sformatf("fill_addr%0d", i), 64'(wr_addr_q[i]), 64'h1000 + 64'(4 * i));
        check_value($sformatf("fill_data%0d", i), 64'(wr_data_q[i]), 64'hD0 + 64'(i));
        check_value($sformatf("fill_cyc%0d", i),  64'(wr_cyc_q[i] - wr_cyc_q[0]), 64'(i));
      end
    end
    check_value("fill_end_count", 64'(bus.sb_count), 64'd0);
    check_value("fill_end_ready", 64'(bus.st_ready), 64'd1);

    // Four stores, two committed, then flush: only the committed pair drains
    for (int i = 0; i < 4; i++) enq(4'(8 + i), 32'h3000 + 32'(4 * i), 32'h300 + 32'(i));
    check_value("fl_count4", 64'(bus.sb_count), 64'd4);
    clear_writes();
    commit(4'd8);
    commit(4'd9);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    wait_idle("fl_idle");
    check_value("fl_nwrites", 64'(wr_addr_q.size()), 64'd2);
    if (wr_addr_q.size() == 2) begin
      check_value("fl_addr0", 64'(wr_addr_q[0]), 64'h3000);
      check_value("fl_addr1", 64'(wr_addr_q[1]), 64'h3004);
    end
    check_value("fl_count0", 64'(bus.sb_count), 64'd0);
    bus.ld_addr = 32'h3008;
    #1;
    check_value("fl_ld_gone", 64'(bus.ld_match), 64'd0);
    enq(4'd12, 32'h3100, 32'h31);
    commit(4'd12);
    wait_idle("fl_reenq_idle");
    check_value("fl_reenq_err", 64'(bus.commit_err), 64'd0);
    check_value("fl_reenq_nwrites", 64'(wr_addr_q.size()), 64'd3);
    if (wr_addr_q.size() == 3) check_value("fl_reenq_addr", 64'(wr_addr_q[2]), 64'h3100);

    // Three stalled cycles hold the request stable, then exactly one write is accepted
    clear_writes();
    enq(4'd13, 32'h4000, 32'h55);
    commit(4'd13);
    bus.dc_stall = 1'b1;
    step();
    bus.ld_addr = 32'h4000;
    #1;
    check_value("stall_fwd_match", 64'(bus.ld_match),    64'd1);
    check_value("stall_fwd_data",  64'(bus.ld_fwd_data), 64'h55);
    for (int k = 0; k < 3; k++) begin
      check_value($sformatf("stall_valid%0d", k), 64'(bus.dc_wr_valid), 64'd1);
      check_value($sformatf("stall_addr%0d", k),  64'(bus.dc_wr_addr),  64'h4000);
      check_value($sformatf("stall_data%0d", k),  64'(bus.dc_wr_data),  64'h55);
      step();
    end
    bus.dc_stall = 1'b0;
    check_value("stall_accept_valid", 64'(bus.dc_wr_valid), 64'd1);
    step();
    check_value("stall_after_valid", 64'(bus.dc_wr_valid), 64'd0);
    check_value("stall_nwrites", 64'(wr_addr_q.size()), 64'd1);

    // Wrong-tag commit sets a sticky error without changing state
    enq(4'd4, 32'h5000, 32'h50);
    enq(4'd5, 32'h5004, 32'h51);
    check_value("err_pre", 64'(bus.commit_err), 64'd0);
    clear_writes();
    commit(4'd5);
    check_value("err_set",   64'(bus.commit_err), 64'd1);
    check_value("err_count", 64'(bus.sb_count),   64'd2);
    step();
    step();
    step();
    check_value("err_nowrite", 64'(wr_addr_q.size()), 64'd0);
    commit(4'd4);
    commit(4'd5);
    wait_idle("err_idle");
    check_value("err_nwrites", 64'(wr_addr_q.size()), 64'd2);
    check_value("err_sticky", 64'(bus.commit_err), 64'd1);
    do_reset();
    check_value("err_rst_clear", 64'(bus.commit_err), 64'd0);
    commit(4'd0);
    check_value("err_empty_set",   64'(bus.commit_err), 64'd1);
    check_value("err_empty_count", 64'(bus.sb_count),   64'd0);
    check_value("err_empty_empty", 64'(bus.sb_empty),   64'd1);

    // Reset during ISSUE drops the in-flight write
    do_reset();
    check_value("rst2_err", 64'(bus.commit_err), 64'd0);
    enq(4'd1, 32'h6000, 32'h66);
    bus.dc_stall = 1'b1;
    commit(4'd1);
    step();
    check_value("midrst_valid_pre", 64'(bus.dc_wr_valid), 64'd1);
    do_reset();
    bus.dc_stall = 1'b0;
    check_value("midrst_valid", 64'(bus.dc_wr_valid), 64'd0);
    check_value("midrst_addr",  64'(bus.dc_wr_addr),  64'd0);
    check_value("midrst_empty", 64'(bus.sb_empty),    64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

endmodule
